// File: rtl/rf_write_arbiter_if.sv
// Bundle of write-back, multi-cycle result and register-file write-port
// signals shared between the producer side and the arbiter.
interface rf_write_arbiter_if #(
    parameter int XLEN = 32
);
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_result;
    logic            mc_valid;
    logic            mc_ready;
    logic [4:0]      mc_rd;
    logic [XLEN-1:0] mc_data;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            stall_wb;
    logic            busy;
    logic [31:0]     pending_mask;

    modport master (
        output wb_reg_write, wb_rd, wb_result, mc_valid, mc_rd, mc_data,
        input  mc_ready, rf_we, rf_waddr, rf_wdata, stall_wb, busy, pending_mask
    );

    modport slave (
        input  wb_reg_write, wb_rd, wb_result, mc_valid, mc_rd, mc_data,
        output mc_ready, rf_we, rf_waddr, rf_wdata, stall_wb, busy, pending_mask
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter. Write-back has priority and passes
// straight through; multi-cycle results queue in a small FIFO and drain into
// idle port cycles. A starvation counter steals one WB cycle to force a drain.
module rf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int XLEN         = 32
) (
    input logic               clk,
    input logic               rstn,
    rf_write_arbiter_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT     = CW'(1);
    localparam logic [PW-1:0] ONE_PTR     = PW'(1);
    localparam logic [SW-1:0] ONE_STARVE  = SW'(1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

    logic [4:0]      rd_mem_r   [DEPTH];
    logic [XLEN-1:0] data_mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [SW-1:0]   starve_r;
    logic            stall_r;
    logic            ready_r;

    logic            empty_s;
    logic            wb_act_s;
    logic            head_grant_s;
    logic            enq_s;
    logic            stall_next_s;
    logic [4:0]      head_rd_s;
    logic [XLEN-1:0] head_data_s;
    logic            rf_we_s;
    logic [4:0]      rf_waddr_s;
    logic [XLEN-1:0] rf_wdata_s;
    logic [CW-1:0]   count_next_s;
    logic [31:0]     mask_s;

    assign empty_s     = (count_r == {CW{1'b0}});
    assign head_rd_s   = rd_mem_r[rd_ptr_r];
    assign head_data_s = data_mem_r[rd_ptr_r];
    assign wb_act_s    = bus.wb_reg_write && (bus.wb_rd != 5'd0) && !stall_r;
    // mc_ready is registered from the cycle-start count, so a full FIFO
    // never accepts even when its head drains in the same cycle.
    assign enq_s       = bus.mc_valid && ready_r;
    // Stall once the head has waited STARVE_LIMIT cycles; never twice in a row.
    assign stall_next_s = !stall_r && !empty_s && !head_grant_s && (starve_r == STARVE_LAST);

    // Port grant: forced drain, else WB, else FIFO head; rd=0 heads drain silently.
    always_comb begin
        head_grant_s = 1'b0;
        rf_we_s      = 1'b0;
        rf_waddr_s   = 5'd0;
        rf_wdata_s   = {XLEN{1'b0}};
        if (stall_r || !wb_act_s) begin
            head_grant_s = !empty_s;
            if (!empty_s && (head_rd_s != 5'd0)) begin
                rf_we_s    = 1'b1;
                rf_waddr_s = head_rd_s;
                rf_wdata_s = head_data_s;
            end else begin
                rf_we_s    = 1'b0;
            end
        end else begin
            rf_we_s    = 1'b1;
            rf_waddr_s = bus.wb_rd;
            rf_wdata_s = bus.wb_result;
        end
    end

    // Occupancy after this cycle's enqueue/dequeue.
    always_comb begin
        case ({enq_s, head_grant_s})
            2'b10:   count_next_s = count_r + ONE_CNT;
            2'b01:   count_next_s = count_r - ONE_CNT;
            default: count_next_s = count_r;
        endcase
    end

    // Pending-destination mask over the live FIFO window (x0 never reported).
    always_comb begin
        mask_s = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PW'(i) - rd_ptr_r} < count_r) begin
                mask_s[rd_mem_r[i]] = 1'b1;
            end else begin
                mask_s = mask_s;
            end
        end
        mask_s[0] = 1'b0;
    end

    // FIFO storage written at the tail on an accepted MC result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_r[i]   <= 5'd0;
                data_mem_r[i] <= {XLEN{1'b0}};
            end
        end else if (enq_s) begin
            rd_mem_r[wr_ptr_r]   <= bus.mc_rd;
            data_mem_r[wr_ptr_r] <= bus.mc_data;
        end
    end

    // Pointers, occupancy, ready, starvation counter and WB stall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            starve_r <= {SW{1'b0}};
            stall_r  <= 1'b0;
            ready_r  <= 1'b0;
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (head_grant_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != FULL_CNT);
            if (head_grant_s || empty_s) begin
                starve_r <= {SW{1'b0}};
            end else begin
                starve_r <= starve_r + ONE_STARVE;
            end
            stall_r <= stall_next_s;
        end
    end

    assign bus.mc_ready     = ready_r;
    assign bus.rf_we        = rf_we_s;
    assign bus.rf_waddr     = rf_waddr_s;
    assign bus.rf_wdata     = rf_wdata_s;
    assign bus.stall_wb     = stall_r;
    assign bus.busy         = !empty_s;
    assign bus.pending_mask = mask_s;
endmodule
